// File: rtl/alu_arbiter.sv
// Two-port front end for a single shared ALU: grants one requester at a time,
// walks each transaction through IDLE -> EXEC -> RESP and holds the result until consumed.
module alu_arbiter #(
  parameter int RR_EN  = 1,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              r0_valid,
  output logic              r0_ready,
  input  logic [3:0]        r0_ctrl,
  input  logic [DATA_W-1:0] r0_src1,
  input  logic [DATA_W-1:0] r0_src2,
  output logic              r0_rsp_valid,
  input  logic              r0_rsp_ready,
  output logic [DATA_W-1:0] r0_result,
  output logic              r0_z,
  input  logic              r1_valid,
  output logic              r1_ready,
  input  logic [3:0]        r1_ctrl,
  input  logic [DATA_W-1:0] r1_src1,
  input  logic [DATA_W-1:0] r1_src2,
  output logic              r1_rsp_valid,
  input  logic              r1_rsp_ready,
  output logic [DATA_W-1:0] r1_result,
  output logic              r1_z,
  output logic [3:0]        alu_ctrl,
  output logic [DATA_W-1:0] alu_src1,
  output logic [DATA_W-1:0] alu_src2,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_z
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t              state_q, state_d;
  logic                grant_q, grant_d;
  logic                last_grant_q, last_grant_d;
  logic [3:0]          opc_q, opc_d;
  logic [DATA_W-1:0]   op1_q, op1_d;
  logic [DATA_W-1:0]   op2_q, op2_d;
  logic [DATA_W-1:0]   result_q [2];
  logic [DATA_W-1:0]   result_d [2];
  logic [1:0]          z_q, z_d;
  logic [1:0]          rsp_valid_q, rsp_valid_d;
  logic [1:0]          req, rsp_rdy, ready;
  logic                win;

  assign req     = {r1_valid, r0_valid};
  assign rsp_rdy = {r1_rsp_ready, r0_rsp_ready};

  // A tie goes to the port that did not complete last (round-robin) or to port 0.
  always_comb begin
    if (req == 2'b11) win = (RR_EN != 0) ? ~last_grant_q : 1'b0;
    else              win = req[1];
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    opc_d        = opc_q;
    op1_d        = op1_q;
    op2_d        = op2_q;
    result_d     = result_q;
    z_d          = z_q;
    rsp_valid_d  = rsp_valid_q;
    ready        = 2'b00;
    case (state_q)
      IDLE: begin
        if (|req) begin
          ready[win] = 1'b1;
          grant_d    = win;
          opc_d      = win ? r1_ctrl : r0_ctrl;
          op1_d      = win ? r1_src1 : r0_src1;
          op2_d      = win ? r1_src2 : r0_src2;
          state_d    = EXEC;
        end
      end
      EXEC: begin
        result_d[grant_q]    = alu_result;
        z_d[grant_q]         = alu_z;
        rsp_valid_d[grant_q] = 1'b1;
        state_d              = RESP;
      end
      RESP: begin
        if (rsp_rdy[grant_q]) begin
          rsp_valid_d[grant_q] = 1'b0;
          last_grant_d         = grant_q;
          state_d              = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      opc_q        <= '0;
      op1_q        <= '0;
      op2_q        <= '0;
      result_q     <= '{default: '0};
      z_q          <= '0;
      rsp_valid_q  <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      opc_q        <= opc_d;
      op1_q        <= op1_d;
      op2_q        <= op2_d;
      result_q     <= result_d;
      z_q          <= z_d;
      rsp_valid_q  <= rsp_valid_d;
    end
  end

  // Reset wins over a same-cycle grant so nothing is accepted during reset.
  assign r0_ready     = ready[0] & ~rst;
  assign r1_ready     = ready[1] & ~rst;
  assign r0_rsp_valid = rsp_valid_q[0];
  assign r1_rsp_valid = rsp_valid_q[1];
  assign r0_result    = result_q[0];
  assign r1_result    = result_q[1];
  assign r0_z         = z_q[0];
  assign r1_z         = z_q[1];
  assign alu_ctrl     = opc_q;
  assign alu_src1     = op1_q;
  assign alu_src2     = op2_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench: a round-robin and a fixed-priority arbiter share stimulus,
// each with its own stub ALU and transaction-level reference model.
module tb_alu_arbiter;

  logic        clk, rst;
  logic        r0_valid, r1_valid, r0_rsp_ready, r1_rsp_ready;
  logic [3:0]  r0_ctrl, r1_ctrl;
  logic [31:0] r0_src1, r0_src2, r1_src1, r1_src2;

  logic        rdy  [2][2];
  logic        rspv [2][2];
  logic [31:0] res  [2][2];
  logic        zf   [2][2];
  logic [3:0]  actl [2];
  logic [31:0] as1 [2], as2 [2], ares [2];
  logic        az [2];

  int cyc   = 0;
  int nvec  = 0;
  int nfail = 0;

  typedef struct {int port; logic [31:0] res; logic z;} exp_t;
  exp_t sb0[$], sb1[$];
  int   glog0[$], glog1[$];

  int          busy [2] = '{0, 0};
  int          lg   [2] = '{1, 1};
  int          acc  [2] = '{0, 0};
  logic [31:0] lres [2][2] = '{'{32'h0, 32'h0}, '{32'h0, 32'h0}};
  logic        lz   [2][2] = '{'{1'b0, 1'b0}, '{1'b0, 1'b0}};
  logic [3:0]  opc  [2] = '{4'h0, 4'h0};
  logic [31:0] op1  [2] = '{32'h0, 32'h0};
  logic [31:0] op2  [2] = '{32'h0, 32'h0};

  function automatic logic [32:0] alu_ref(input logic [3:0] c, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [31:0] r;
    case (c)
      4'd0:    r = a + b;
      4'd1:    r = a - b;
      4'd2:    r = a & b;
      4'd3:    r = a | b;
      4'd4:    r = {31'b0, $signed(a) < $signed(b)};
      4'd5:    r = {31'b0, a < b};
      4'd6:    r = a ^ b;
      4'd7:    r = b;
      4'd8:    r = a << b[4:0];
      4'd9:    r = $unsigned($signed(a) >>> b[4:0]);
      4'd10:   r = a >> b[4:0];
      default: r = 32'h0;
    endcase
    return {(r == 32'h0), r};
  endfunction

  assign {az[0], ares[0]} = alu_ref(actl[0], as1[0], as2[0]);
  assign {az[1], ares[1]} = alu_ref(actl[1], as1[1], as2[1]);

  alu_arbiter #(.RR_EN(1)) dut_rr (
    .clk(clk), .rst(rst),
    .r0_valid(r0_valid), .r0_ready(rdy[0][0]), .r0_ctrl(r0_ctrl), .r0_src1(r0_src1),
    .r0_src2(r0_src2), .r0_rsp_valid(rspv[0][0]), .r0_rsp_ready(r0_rsp_ready),
    .r0_result(res[0][0]), .r0_z(zf[0][0]),
    .r1_valid(r1_valid), .r1_ready(rdy[0][1]), .r1_ctrl(r1_ctrl), .r1_src1(r1_src1),
    .r1_src2(r1_src2), .r1_rsp_valid(rspv[0][1]), .r1_rsp_ready(r1_rsp_ready),
    .r1_result(res[0][1]), .r1_z(zf[0][1]),
    .alu_ctrl(actl[0]), .alu_src1(as1[0]), .alu_src2(as2[0]),
    .alu_result(ares[0]), .alu_z(az[0])
  );

  alu_arbiter #(.RR_EN(0)) dut_fp (
    .clk(clk), .rst(rst),
    .r0_valid(r0_valid), .r0_ready(rdy[1][0]), .r0_ctrl(r0_ctrl), .r0_src1(r0_src1),
    .r0_src2(r0_src2), .r0_rsp_valid(rspv[1][0]), .r0_rsp_ready(r0_rsp_ready),
    .r0_result(res[1][0]), .r0_z(zf[1][0]),
    .r1_valid(r1_valid), .r1_ready(rdy[1][1]), .r1_ctrl(r1_ctrl), .r1_src1(r1_src1),
    .r1_src2(r1_src2), .r1_rsp_valid(rspv[1][1]), .r1_rsp_ready(r1_rsp_ready),
    .r1_result(res[1][1]), .r1_z(zf[1][1]),
    .alu_ctrl(actl[1]), .alu_src1(as1[1]), .alu_src2(as2[1]),
    .alu_result(ares[1]), .alu_z(az[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s @cyc %0d: got 0x%08h expected 0x%08h", nm, cyc, act, exp);
    end
  endtask

  function automatic int sb_size(input int d);
    return (d == 0) ? sb0.size() : sb1.size();
  endfunction

  function automatic exp_t sb_front(input int d);
    if (d == 0) return sb0[0];
    return sb1[0];
  endfunction

  task automatic sb_push(input int d, input exp_t e);
    if (d == 0) begin sb0.push_back(e); glog0.push_back(e.port); end
    else        begin sb1.push_back(e); glog1.push_back(e.port); end
  endtask

  task automatic sb_pop(input int d);
    if (d == 0) void'(sb0.pop_front());
    else        void'(sb1.pop_front());
  endtask

  task automatic chk_dut(input int d);
    string nm;
    int    win;
    bit    v0, v1, expv, rr;
    exp_t  e;
    nm = (d == 0) ? "rr" : "fp";
    rr = (d == 0);
    v0 = (r0_valid === 1'b1);
    v1 = (r1_valid === 1'b1);
    chk({nm, "_alu_ctrl"}, {28'h0, actl[d]}, {28'h0, opc[d]});
    chk({nm, "_alu_src1"}, as1[d], op1[d]);
    chk({nm, "_alu_src2"}, as2[d], op2[d]);
    // Request side: predict the winner from the request rules.
    win = -1;
    if (rst !== 1'b1 && busy[d] == 0) begin
      if (v0 && v1) win = rr ? (1 - lg[d]) : 0;
      else if (v0)  win = 0;
      else if (v1)  win = 1;
    end
    chk({nm, "_ready0"}, {31'h0, rdy[d][0]}, {31'h0, (win == 0)});
    chk({nm, "_ready1"}, {31'h0, rdy[d][1]}, {31'h0, (win == 1)});
    if (win >= 0) begin
      e.port = win;
      opc[d] = (win == 1) ? r1_ctrl : r0_ctrl;
      op1[d] = (win == 1) ? r1_src1 : r0_src1;
      op2[d] = (win == 1) ? r1_src2 : r0_src2;
      {e.z, e.res} = alu_ref(opc[d], op1[d], op2[d]);
      sb_push(d, e);
      busy[d] = 1;
      acc[d]  = cyc;
    end
    // Response side: the front entry is due two cycles after acceptance.
    for (int p = 0; p < 2; p++) begin
      expv = (sb_size(d) > 0) && (sb_front(d).port == p) && (cyc >= acc[d] + 2);
      chk($sformatf("%s_rsp_valid%0d", nm, p), {31'h0, rspv[d][p]}, {31'h0, expv});
      if (expv) begin
        lres[d][p] = sb_front(d).res;
        lz[d][p]   = sb_front(d).z;
      end
      chk($sformatf("%s_result%0d", nm, p), res[d][p], lres[d][p]);
      chk($sformatf("%s_z%0d", nm, p), {31'h0, zf[d][p]}, {31'h0, lz[d][p]});
      if (expv && ((p == 0) ? r0_rsp_ready : r1_rsp_ready) === 1'b1) begin
        sb_pop(d);
        lg[d]   = p;
        busy[d] = 0;
      end
    end
    if (rst === 1'b1) begin
      if (d == 0) sb0.delete(); else sb1.delete();
      busy[d] = 0;
      lg[d]   = 1;
      opc[d]  = 4'h0;
      op1[d]  = 32'h0;
      op2[d]  = 32'h0;
      for (int p = 0; p < 2; p++) begin
        lres[d][p] = 32'h0;
        lz[d][p]   = 1'b0;
      end
    end
  endtask

  always @(negedge clk) begin
    chk_dut(0);
    chk_dut(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    r0_valid = 1'b0; r1_valid = 1'b0;
    r0_rsp_ready = 1'b1; r1_rsp_ready = 1'b1;
    r0_ctrl = 4'h0; r1_ctrl = 4'h0;
    r0_src1 = 32'h0; r0_src2 = 32'h0; r1_src1 = 32'h0; r1_src2 = 32'h0;
    repeat (2) tick;
    rst = 1'b0;

    // r0 add 5+7: response two cycles after acceptance
    r0_valid = 1'b1; r0_ctrl = 4'd0; r0_src1 = 32'd5; r0_src2 = 32'd7;
    tick;
    r0_valid = 1'b0;
    tick;
    for (int d = 0; d < 2; d++) begin
      chk("add_rsp_valid", {31'h0, rspv[d][0]}, 32'd1);
      chk("add_result", res[d][0], 32'd12);
      chk("add_z", {31'h0, zf[d][0]}, 32'd0);
      chk("add_other_rsp_valid", {31'h0, rspv[d][1]}, 32'd0);
    end
    repeat (2) tick;

    // r1 sub 9-9 gives zero
    r1_valid = 1'b1; r1_ctrl = 4'd1; r1_src1 = 32'd9; r1_src2 = 32'd9;
    tick;
    r1_valid = 1'b0;
    tick;
    for (int d = 0; d < 2; d++) begin
      chk("sub_rsp_valid", {31'h0, rspv[d][1]}, 32'd1);
      chk("sub_result", res[d][1], 32'd0);
      chk("sub_z", {31'h0, zf[d][1]}, 32'd1);
    end
    repeat (2) tick;

    // Both ports request continuously: grant order per arbitration mode
    rst = 1'b1;
    tick;
    rst = 1'b0;
    glog0.delete(); glog1.delete();
    r0_valid = 1'b1; r1_valid = 1'b1;
    r0_ctrl = 4'd3; r1_ctrl = 4'd6;
    r0_src1 = 32'h00F0; r0_src2 = 32'h0F00; r1_src1 = 32'hAAAA; r1_src2 = 32'h5555;
    repeat (12) tick;
    r0_valid = 1'b0; r1_valid = 1'b0;
    chk("rr_grant_count", glog0.size(), 32'd4);
    chk("fp_grant_count", glog1.size(), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < glog0.size()) chk($sformatf("rr_grant%0d", i), glog0[i], i % 2);
      if (i < glog1.size()) chk($sformatf("fp_grant%0d", i), glog1[i], 32'd0);
    end
    repeat (3) tick;

    // sra held under backpressure while r1 waits
    rst = 1'b1;
    tick;
    rst = 1'b0;
    r0_valid = 1'b1; r0_ctrl = 4'd9; r0_src1 = 32'h8000_0000; r0_src2 = 32'd4;
    r1_valid = 1'b1; r1_ctrl = 4'd0; r1_src1 = 32'd1; r1_src2 = 32'd2;
    r0_rsp_ready = 1'b0;
    tick;
    r0_valid = 1'b0;
    repeat (3) tick;
    for (int d = 0; d < 2; d++) begin
      chk("sra_rsp_valid", {31'h0, rspv[d][0]}, 32'd1);
      chk("sra_result", res[d][0], 32'hF800_0000);
    end
    repeat (2) tick;
    r0_rsp_ready = 1'b1;
    tick;
    for (int d = 0; d < 2; d++) chk("r1_after_hs_ready", {31'h0, rdy[d][1]}, 32'd1);
    tick;
    r1_valid = 1'b0;
    repeat (4) tick;

    // Reset during EXEC aborts the transaction
    r0_valid = 1'b1; r0_ctrl = 4'd0; r0_src1 = 32'd100; r0_src2 = 32'd23;
    tick;
    r0_valid = 1'b0;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      chk("abort_rsp_valid", {31'h0, rspv[d][0]}, 32'd0);
      chk("abort_result", res[d][0], 32'd0);
      chk("abort_alu_src1", as1[d], 32'd0);
    end
    repeat (3) tick;

    // Randomized traffic
    repeat (400) begin
      r0_valid     = ($urandom % 3) != 0;
      r1_valid     = ($urandom % 3) != 0;
      r0_ctrl      = 4'($urandom % 16);
      r1_ctrl      = 4'($urandom % 16);
      r0_src1      = $urandom;
      r0_src2      = (($urandom % 4) == 0) ? r0_src1 : $urandom;
      r1_src1      = $urandom;
      r1_src2      = (($urandom % 4) == 0) ? r1_src1 : $urandom;
      r0_rsp_ready = ($urandom % 4) != 0;
      r1_rsp_ready = ($urandom % 4) != 0;
      rst          = ($urandom % 64) == 0;
      tick;
    end
    rst = 1'b0;
    r0_valid = 1'b0; r1_valid = 1'b0;
    r0_rsp_ready = 1'b1; r1_rsp_ready = 1'b1;
    repeat (6) tick;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
